// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, GF(2^8) xtime, round-stage FSM
// states and FIPS-197 byte/column indexing helpers.
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // MSB position of byte k; byte 0 is the leftmost byte of the state.
    function automatic int byte_msb(input int k);
        return AES_STATE_W - 1 - 8 * k;
    endfunction

    function automatic logic [7:0] get_byte(
        input logic [AES_STATE_W-1:0] s,
        input int                     k
    );
        return s[byte_msb(k) -: 8];
    endfunction

    // Column c is bytes 4c..4c+3, row 0 in the top byte of the result.
    function automatic logic [31:0] get_col(
        input logic [AES_STATE_W-1:0] s,
        input logic [1:0]             c
    );
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[31-8*k -: 8] = get_byte(s, 4 * int'(c) + k);
        end
        return r;
    endfunction

    function automatic logic [AES_STATE_W-1:0] set_col(
        input logic [AES_STATE_W-1:0] s,
        input logic [1:0]             c,
        input logic [31:0]            v
    );
        logic [AES_STATE_W-1:0] r;
        r = s;
        for (int k = 0; k < 4; k++) begin
            r[byte_msb(4 * int'(c) + k) -: 8] = v[31-8*k -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// MixColumns for one 32-bit column: {02,03,01,01} circulant over GF(2^8).
// Ports: col_in (row 0 in [31:24]) -> col_out, purely combinational.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    always_comb begin
        a0 = col_in[31:24];
        a1 = col_in[23:16];
        a2 = col_in[15:8];
        a3 = col_in[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // 3*a is xtime(a)^a
        col_out[31:24] = x0 ^ x1 ^ a1 ^ a2 ^ a3;
        col_out[23:16] = a0 ^ x1 ^ x2 ^ a2 ^ a3;
        col_out[15:8]  = a0 ^ a1 ^ x2 ^ x3 ^ a3;
        col_out[7:0]   = x0 ^ a0 ^ a1 ^ a2 ^ x3;
    end

endmodule

// File: rtl/shift_mix_columns.sv
// AES round stage: ShiftRows at accept, then MixColumns one column per cycle.
// Ports: clk, rst_n, in_* (valid/ready, data, skip_mix), out_* (valid/ready, data).
module shift_mix_columns
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_skip_mix,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    fsm_e                   state_q, state_d;
    logic [1:0]             col_q, col_d;
    logic [AES_STATE_W-1:0] st_q, st_d;
    logic [AES_STATE_W-1:0] sr;
    logic [31:0]            mix_in, mix_out;

    // ShiftRows: s'[r][c] = s[r][(c+r) mod 4], wiring only.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[byte_msb(4*c + r) -: 8] =
                    get_byte(in_data, 4*((c + r) % 4) + r);
            end
        end
    end

    assign mix_in = get_col(st_q, col_q);

    mix_single_column u_mix (
        .col_in  (mix_in),
        .col_out (mix_out)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        st_d     = st_q;
        in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d    = sr;
                    col_d   = 2'd0;
                    state_d = in_skip_mix ? DONE : MIX;
                end
            end
            MIX: begin
                st_d  = set_col(st_q, col_q, mix_out);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                in_ready = out_ready;
                // Hand-off and next accept share one edge.
                if (out_ready && in_valid) begin
                    st_d    = sr;
                    col_d   = 2'd0;
                    state_d = in_skip_mix ? DONE : MIX;
                end else if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign out_data  = st_q;

endmodule

// File: tb/tb_shift_mix_columns.sv
// Self-checking bench for shift_mix_columns: matrix-level AES model,
// per-cycle compare of handshake and data, plus FIPS-197 literal vectors.
module tb_shift_mix_columns;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_skip_mix = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    localparam logic [127:0] B_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] B_MIX  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] B_SR   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] C_IN   = {4{32'hdb135345}};
    localparam logic [127:0] C_OUT  = {4{32'h8e4da1bc}};

    shift_mix_columns dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_skip_mix (in_skip_mix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] m_round(input logic [127:0] s,
                                             input logic skip);
        logic [7:0] m [4][4];
        logic [7:0] t [4][4];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] o;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = m[r][(c+r)%4];
        if (!skip) begin
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(coef[(k-r+4)%4], t[k][c]);
                    m[r][c] = acc;
                end
            end
        end else begin
            m = t;
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = m[r][c];
        return o;
    endfunction

    // Timing model: one state in flight, ready after 4 edges (1 if skip).
    logic         m_pend = 1'b0;
    int           m_cnt  = 0;
    logic [127:0] m_data = '0;
    logic         exp_valid, exp_ready;

    assign exp_valid = m_pend && (m_cnt == 0);
    assign exp_ready = !m_pend || (exp_valid && out_ready);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0;
            m_cnt  <= 0;
            m_data <= '0;
        end else begin
            if (m_pend && m_cnt != 0) m_cnt <= m_cnt - 1;
            if (exp_valid && out_ready) m_pend <= 1'b0;
            if (in_valid && exp_ready) begin
                m_pend <= 1'b1;
                m_cnt  <= in_skip_mix ? 0 : 4;
                m_data <= m_round(in_data, in_skip_mix);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
            chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
            if (exp_valid) chk("out_data", out_data, m_data);
            if (out_valid && out_ready) n_out++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n;
        n = 0;
        while (!out_valid && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, want out_valid", name, n);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic skip);
        in_data     = d;
        in_skip_mix = skip;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        chk("pin_mix", m_round(B_IN, 1'b0), B_MIX);
        chk("pin_sr", m_round(B_IN, 1'b1), B_SR);
        chk("pin_col", m_round(C_IN, 1'b0), C_OUT);

        #2;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        tick();

        // Round 1 with MixColumns, held in DONE under backpressure.
        send(B_IN, 1'b0);
        wait_valid(10, "mix_latency");
        chk("mix_data", out_data, B_MIX);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", {127'd0, out_valid}, 128'd1);
            chk("bp_data", out_data, B_MIX);
            chk("bp_ready", {127'd0, in_ready}, 128'd0);
        end
        // Release with a new skip-mode input on the same edge.
        in_data     = B_IN;
        in_skip_mix = 1'b1;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", {127'd0, out_valid}, 128'd1);
        chk("skip_data", out_data, B_SR);
        tick();
        chk("drain_valid", {127'd0, out_valid}, 128'd0);

        // Identical columns.
        send(C_IN, 1'b0);
        wait_valid(10, "col_latency");
        chk("col_data", out_data, C_OUT);
        tick();

        // Skip-mode stream, one per cycle.
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            in_data     = {$urandom, $urandom, $urandom, $urandom};
            in_skip_mix = 1'b1;
            in_valid    = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        chk("stream_count", 128'(n_out - base), 128'd8);

        // Reset while in MIX (col=1).
        send(B_IN, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmix_valid", {127'd0, out_valid}, 128'd0);
        chk("rstmix_data", out_data, 128'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rstmix_ready", {127'd0, in_ready}, 128'd1);
        tick();

        // Reset while in DONE: out_valid falls with rst_n.
        out_ready = 1'b0;
        send(B_IN, 1'b1);
        chk("done_valid", {127'd0, out_valid}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rstdone_valid", {127'd0, out_valid}, 128'd0);
        chk("rstdone_data", out_data, 128'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        send(B_IN, 1'b0);
        wait_valid(10, "post_rst_latency");
        chk("post_rst_data", out_data, B_MIX);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
